// File: rtl/edge_pkg.sv
// Shared types and helpers for the Sobel edge pipeline.
// Lane widths sized for an exact |Gx|+|Gy| magnitude.
package edge_pkg;
  localparam int PIX_W  = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = 32;
  localparam int GRAD_W = 11;
  localparam int MAG_W  = 11;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [MAG_W-1:0] mag_t;

  typedef struct packed {
    logic [WORD_W-1:0] w5;
    logic [WORD_W-1:0] w4;
    logic [WORD_W-1:0] w3;
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w0;
  } win_t;

  // a + 2b + c, zero-extended into the signed gradient width
  function automatic grad_t wsum(pix_t a, pix_t b, pix_t c);
    return grad_t'({3'b000, a})
         + grad_t'({2'b00, b, 1'b0})
         + grad_t'({3'b000, c});
  endfunction

  function automatic mag_t abs_grad(grad_t g);
    return g[GRAD_W-1] ? mag_t'(-g) : mag_t'(g);
  endfunction
endpackage

// File: rtl/sobel_lane.sv
// One Sobel output pixel: registered Gx/Gy, then registered |Gx|+|Gy|.
// The centre pixel carries zero weight in both kernels, so it is not a port.
module sobel_lane
  import edge_pkg::*;
(
  input  logic clk,
  input  pix_t tl,
  input  pix_t tc,
  input  pix_t tr,
  input  pix_t ml,
  input  pix_t mr,
  input  pix_t bl,
  input  pix_t bc,
  input  pix_t br,
  output mag_t mag
);

  grad_t gx_q;
  grad_t gy_q;

  always_ff @(posedge clk) begin
    gx_q <= wsum(tr, mr, br) - wsum(tl, ml, bl);
    gy_q <= wsum(bl, bc, br) - wsum(tl, tc, tr);
    mag  <= abs_grad(gx_q) + abs_grad(gy_q);
  end

endmodule

// File: rtl/sobel_window_stage.sv
// Sobel magnitude over a 3x8 pixel window, 4 lanes per beat,
// 4-cycle latency, with a saturating per-frame edge counter.
module sobel_window_stage
  import edge_pkg::*;
#(
  parameter int THRESHOLD = 128,
  parameter bit BINARY    = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              frame_start,
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w2,
  input  logic [WORD_W-1:0] w3,
  input  logic [WORD_W-1:0] w4,
  input  logic [WORD_W-1:0] w5,
  output logic              out_valid,
  output logic [WORD_W-1:0] pix_out,
  output logic [CNT_W-1:0]  edge_count
);

  localparam mag_t THR = mag_t'(THRESHOLD);

  win_t win_q;
  logic v1, v2, v3;
  logic fs1, fs2, fs3;

  always_ff @(posedge clk) begin
    win_q <= '{w5: w5, w4: w4, w3: w3,
               w2: w2, w1: w1, w0: w0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {v1, v2, v3}    <= '0;
      {fs1, fs2, fs3} <= '0;
    end else begin
      v1  <= in_valid;
      fs1 <= in_valid & frame_start;
      v2  <= v1;
      fs2 <= fs1;
      v3  <= v2;
      fs3 <= fs2;
    end
  end

  logic [2*WORD_W-1:0] top_r, mid_r, bot_r;
  assign top_r = {win_q.w1, win_q.w0};
  assign mid_r = {win_q.w3, win_q.w2};
  assign bot_r = {win_q.w5, win_q.w4};

  mag_t mag [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    sobel_lane u_lane (
      .clk (clk),
      .tl  (top_r[PIX_W*j     +: PIX_W]),
      .tc  (top_r[PIX_W*(j+1) +: PIX_W]),
      .tr  (top_r[PIX_W*(j+2) +: PIX_W]),
      .ml  (mid_r[PIX_W*j     +: PIX_W]),
      .mr  (mid_r[PIX_W*(j+2) +: PIX_W]),
      .bl  (bot_r[PIX_W*j     +: PIX_W]),
      .bc  (bot_r[PIX_W*(j+1) +: PIX_W]),
      .br  (bot_r[PIX_W*(j+2) +: PIX_W]),
      .mag (mag[j])
    );
  end

  logic [WORD_W-1:0] res;
  logic [2:0]        pop;
  logic              hit;

  always_comb begin
    res = '0;
    pop = '0;
    hit = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      hit = mag[j] >= THR;
      pop = pop + {2'b00, hit};
      if (BINARY)
        res[PIX_W*j +: PIX_W] = hit ? 8'hFF : 8'h00;
      else if (mag[j][MAG_W-1:PIX_W] != '0)
        res[PIX_W*j +: PIX_W] = 8'hFF;
      else
        res[PIX_W*j +: PIX_W] = mag[j][PIX_W-1:0];
    end
  end

  logic [CNT_W:0] sum;
  assign sum = {1'b0, edge_count} + (CNT_W+1)'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      pix_out    <= '0;
      edge_count <= '0;
    end else begin
      out_valid <= v3;
      pix_out   <= res;
      if (v3) begin
        if (fs3)
          edge_count <= CNT_W'(pop);
        else if (sum[CNT_W])
          edge_count <= '1;
        else
          edge_count <= sum[CNT_W-1:0];
      end
    end
  end

endmodule
